// File: rtl/uart_conf_rx.sv
// -----------------------------------------------------------------------------
// uart_conf_rx
//
// UART configuration receiver. It parses ASCII decimal lines such as
// "72,4,24,2,45\n" into CH_NUM configuration channels of PAR_W bits each.
// Field values are gathered in shadow registers. They are copied to `conf`
// in a single cycle, and only after a complete and valid line, so the
// consuming timing core never sees a half-updated configuration.
//
// Optional feature: define CONF_PARITY_EN to receive 8E1 frames. Each frame
// then carries a 9th, even-parity bit. With the macro undefined the frame is
// 8N1 and no parity logic exists.
//
// Parameters:
//   BIT_CLKS  clk cycles per UART bit (>= 8)
//   CH_NUM    number of configuration channels (1..16)
//   PAR_W     width of each channel value (4..32)
//   DIG_MAX   maximum decimal digits per field
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   uart_data   asynchronous serial input, idle high
//   conf        committed values, channel i at [i*PAR_W +: PAR_W]
//   conf_valid  one-cycle pulse when conf is updated
//   err         one-cycle error pulse
//   err_code    error cause, held until the next error
//               (0 frame/parity, 1 illegal char, 2 overflow, 3 field count/empty)
//   state       receiver FSM state (0 IDLE, 1 START, 2 DATA, 3 STOP)
// -----------------------------------------------------------------------------
module uart_conf_rx #(
  parameter int BIT_CLKS = 434,
  parameter int CH_NUM   = 5,
  parameter int PAR_W    = 16,
  parameter int DIG_MAX  = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      uart_data,
  output logic [CH_NUM*PAR_W-1:0]   conf,
  output logic                      conf_valid,
  output logic                      err,
  output logic [1:0]                err_code,
  output logic [1:0]                state
);

  localparam int CNT_W = $clog2(BIT_CLKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BIT_CLKS / 2 - 1);

`ifdef CONF_PARITY_EN
  localparam logic [3:0] BIT_LAST = 4'd8;  // 8 data bits + parity
`else
  localparam logic [3:0] BIT_LAST = 4'd7;  // 8 data bits
`endif

  localparam int IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CH_NUM - 1);

  // The digit counter saturates at DIG_MAX+1. That value is enough to tell
  // that a field has too many digits.
  localparam int DIG_W = $clog2(DIG_MAX + 2);
  localparam logic [DIG_W-1:0] DIG_LIM = DIG_W'(DIG_MAX);
  localparam logic [DIG_W-1:0] DIG_SAT = DIG_W'(DIG_MAX + 1);

  localparam logic [PAR_W+3:0] ACC_MAX = {4'b0000, {PAR_W{1'b1}}};

  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } rx_state_e;

  typedef enum logic [1:0] {
    E_FRAME = 2'd0,
    E_CHAR  = 2'd1,
    E_OVF   = 2'd2,
    E_COUNT = 2'd3
  } err_e;

  // ---------------------------------------------------------------------------
  // Input synchroniser and arming
  // ---------------------------------------------------------------------------
  // `armed` stays low after reset until the line has been seen high. A frame
  // that is already in progress when reset releases is therefore not mistaken
  // for a start bit. The synchroniser resets low so that this check sees the
  // real line level and not a reset value.
  logic sync1;
  logic rx_s;
  logic armed;

  // NOTE: state registers use non-blocking assignments. Every flop then
  // samples the pre-edge value, whatever order the processes run in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      rx_s  <= 1'b0;
      armed <= 1'b0;
    end else begin
      sync1 <= uart_data;
      rx_s  <= sync1;
      if (rx_s) armed <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------------
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       bit_q;
  logic [7:0]       shreg_q;
  logic             par_ok;
  logic             byte_stb;
  logic             frame_err;

`ifdef CONF_PARITY_EN
  logic par_q;
  // Even parity: the parity bit equals the XOR of the eight data bits.
  assign par_ok = ((^shreg_q) == par_q);
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of a combinational process gets a default first.
  // A path that leaves a signal unassigned would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    byte_stb  = 1'b0;
    frame_err = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (armed && !rx_s) state_d = S_START;
      end
      S_START: begin
        // Mid-point of the start bit. A high line here was only a glitch.
        if (cnt_q == CNT_HALF) state_d = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST && bit_q == BIT_LAST) state_d = S_STOP;
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          if (rx_s && par_ok) byte_stb  = 1'b1;
          else                frame_err = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bit timing counter and shift register. The counter restarts in IDLE.
  // Every later sample point therefore follows from the detected start edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
`ifdef CONF_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          bit_q <= '0;
        end
        S_START: begin
          cnt_q <= (cnt_q == CNT_HALF) ? '0 : cnt_q + 1'b1;
        end
        S_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            bit_q <= (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
`ifdef CONF_PARITY_EN
            if (bit_q == 4'd8) par_q <= rx_s;
            else               shreg_q <= {rx_s, shreg_q[7:1]};
`else
            shreg_q <= {rx_s, shreg_q[7:1]};   // LSB arrives first
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  assign state = state_q;

  // ---------------------------------------------------------------------------
  // Line parser
  // ---------------------------------------------------------------------------
  logic [PAR_W-1:0]        acc_q;
  logic [IDX_W-1:0]        idx_q;
  logic [DIG_W-1:0]        dig_q;
  logic                    bad_q;    // line already reported an error
  logic                    empty_q;  // some completed field had no digits
  logic [PAR_W-1:0]        shadow_q [CH_NUM];

  logic                    is_digit;
  logic                    is_comma;
  logic                    is_lf;
  logic                    is_cr;
  logic [PAR_W+3:0]        acc_ext;
  logic [PAR_W+3:0]        prod;
  logic [DIG_W-1:0]        dig_inc;
  logic                    line_ok;
  logic                    raise;
  err_e                    raise_code;
  logic                    commit;
  logic [CH_NUM*PAR_W-1:0] commit_vec;

  assign is_digit = (shreg_q >= 8'h30) && (shreg_q <= 8'h39);
  assign is_comma = (shreg_q == CH_COMMA);
  assign is_lf    = (shreg_q == CH_LF);
  assign is_cr    = (shreg_q == CH_CR);

  // acc*10 + d uses shifts and adds. The 4 extra bits hold any result, so
  // an overflow shows up as a value above the PAR_W-bit maximum.
  assign acc_ext = {4'b0000, acc_q};
  assign prod    = (acc_ext << 3) + (acc_ext << 1) + {{PAR_W{1'b0}}, shreg_q[3:0]};
  assign dig_inc = (dig_q == DIG_SAT) ? dig_q : dig_q + 1'b1;

  // Conditions a line must meet at '\n' to commit. The last field is the
  // one still in acc.
  assign line_ok = (idx_q == IDX_LAST) && !bad_q && !empty_q && (dig_q != '0);

  always_comb begin
    for (int i = 0; i < CH_NUM; i++) begin
      commit_vec[i*PAR_W +: PAR_W] = (IDX_W'(i) == idx_q) ? acc_q : shadow_q[i];
    end
  end

  // Error cause for this byte, before the rule that a bad line reports only
  // its first error. That suppression is applied at the register.
  always_comb begin
    raise      = 1'b0;
    raise_code = E_FRAME;
    commit     = 1'b0;
    if (frame_err) begin
      raise      = 1'b1;
      raise_code = E_FRAME;
    end else if (byte_stb) begin
      if (is_digit) begin
        if (prod > ACC_MAX || dig_inc > DIG_LIM) begin
          raise      = 1'b1;
          raise_code = E_OVF;
        end
      end else if (is_comma) begin
        if (idx_q == IDX_LAST) begin
          raise      = 1'b1;
          raise_code = E_COUNT;
        end
      end else if (is_lf) begin
        commit = line_ok;
        if (!line_ok) begin
          raise      = 1'b1;
          raise_code = E_COUNT;
        end
      end else if (!is_cr) begin
        raise      = 1'b1;
        raise_code = E_CHAR;
      end
    end
  end

  // NOTE: the shadow array is reset explicitly. A reset that clears it
  // keeps a partial first line from committing stale power-up contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q      <= '0;
      idx_q      <= '0;
      dig_q      <= '0;
      bad_q      <= 1'b0;
      empty_q    <= 1'b0;
      for (int i = 0; i < CH_NUM; i++) shadow_q[i] <= '0;
      conf       <= '0;
      conf_valid <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'd0;
    end else begin
      conf_valid <= commit;
      err        <= raise && !bad_q;
      if (raise && !bad_q) err_code <= raise_code;
      if (commit) conf <= commit_vec;

      if (frame_err) begin
        // The byte is lost. The line it belonged to cannot be trusted.
        bad_q <= 1'b1;
      end else if (byte_stb) begin
        if (is_digit) begin
          acc_q <= prod[PAR_W-1:0];
          dig_q <= dig_inc;
          if (raise) bad_q <= 1'b1;
        end else if (is_comma) begin
          if (idx_q != IDX_LAST) begin
            shadow_q[idx_q] <= acc_q;
            idx_q           <= idx_q + 1'b1;
            if (dig_q == '0) empty_q <= 1'b1;
          end else begin
            bad_q <= 1'b1;
          end
          acc_q <= '0;
          dig_q <= '0;
        end else if (is_lf) begin
          shadow_q[idx_q] <= acc_q;
          acc_q   <= '0;
          idx_q   <= '0;
          dig_q   <= '0;
          bad_q   <= 1'b0;
          empty_q <= 1'b0;
        end else if (!is_cr) begin
          bad_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_conf_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_conf_rx
//
// Directed bench for uart_conf_rx with BIT_CLKS=16, CH_NUM=5, PAR_W=16.
// The bench sends each byte as a serial frame. Before a byte is transmitted,
// a line-level model derives from the ASCII content whatever must come out of
// the DUT: a commit with its full conf value, an error with its code, or
// nothing. The model queues that expectation. A compare process pops the
// queue on every conf_valid/err pulse. On all other cycles it checks that
// conf and err_code hold their last values. Literal values in the main
// sequence pin the model itself.
// -----------------------------------------------------------------------------
module tb_uart_conf_rx;

  localparam int BIT_CLKS = 16;
  localparam int CH_NUM   = 5;
  localparam int PAR_W    = 16;
  localparam int DIG_MAX  = 5;
  localparam int CW       = CH_NUM * PAR_W;

  logic          clk;
  logic          rst_n;
  logic          uart_data;
  logic [CW-1:0] conf;
  logic          conf_valid;
  logic          err;
  logic [1:0]    err_code;
  logic [1:0]    state;

  uart_conf_rx #(
    .BIT_CLKS (BIT_CLKS),
    .CH_NUM   (CH_NUM),
    .PAR_W    (PAR_W),
    .DIG_MAX  (DIG_MAX)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_data  (uart_data),
    .conf       (conf),
    .conf_valid (conf_valid),
    .err        (err),
    .err_code   (err_code),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total   = 0;
  int bad_cnt = 0;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Line-level model
  // ---------------------------------------------------------------------------
  typedef struct {
    bit            is_err;
    logic [1:0]    code;
    logic [CW-1:0] conf;
  } ev_t;

  ev_t    exp_q[$];
  longint m_vals[$];   // completed field values of the current line
  bit     m_had[$];    // whether each completed field had a digit
  longint m_cur;
  int     m_dig;
  bit     m_bad;

  logic [CW-1:0] model_conf = '0;
  logic [1:0]    model_code = 2'd0;

  function automatic void model_clear_line();
    m_vals.delete();
    m_had.delete();
    m_cur = 0;
    m_dig = 0;
    m_bad = 0;
  endfunction

  function automatic void model_err(input logic [1:0] code);
    ev_t e;
    if (!m_bad) begin
      e.is_err = 1'b1;
      e.code   = code;
      e.conf   = '0;
      exp_q.push_back(e);
    end
    m_bad = 1;
  endfunction

  function automatic void model_byte(input byte c);
    ev_t           e;
    bit            ok;
    longint        t;
    logic [CW-1:0] v;
    if (c >= 8'h30 && c <= 8'h39) begin
      m_cur = m_cur * 10 + longint'(c - 8'h30);
      m_dig++;
      if (m_cur > 65535 || m_dig > DIG_MAX) model_err(2'd2);
    end else if (c == 8'h2C) begin
      if (m_vals.size() == CH_NUM - 1) model_err(2'd3);
      else begin
        m_vals.push_back(m_cur);
        m_had.push_back(m_dig > 0);
      end
      m_cur = 0;
      m_dig = 0;
    end else if (c == 8'h0A) begin
      m_vals.push_back(m_cur);
      m_had.push_back(m_dig > 0);
      ok = (m_vals.size() == CH_NUM) && !m_bad;
      foreach (m_had[i]) if (!m_had[i]) ok = 0;
      if (ok) begin
        v = '0;
        for (int i = 0; i < CH_NUM; i++) begin
          t = m_vals[i];
          v[i*PAR_W +: PAR_W] = t[PAR_W-1:0];
        end
        e.is_err = 1'b0;
        e.code   = 2'd0;
        e.conf   = v;
        exp_q.push_back(e);
      end else begin
        model_err(2'd3);
      end
      model_clear_line();
    end else if (c != 8'h0D) begin
      model_err(2'd1);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Compare process: outputs are sampled on the falling edge
  // ---------------------------------------------------------------------------
  ev_t cur_ev;
  int  cv_seen  = 0;
  int  err_seen = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (conf_valid || err) begin
        if (conf_valid) cv_seen++;
        if (err)        err_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", CW'({conf_valid, err}), CW'(2'b00));
        end else begin
          cur_ev = exp_q.pop_front();
          if (cur_ev.is_err) begin
            check("err_pulse_kind", CW'({err, conf_valid}), CW'(2'b10));
            check("err_code_value", CW'(err_code), CW'(cur_ev.code));
            model_code = cur_ev.code;
          end else begin
            check("commit_pulse_kind", CW'({err, conf_valid}), CW'(2'b01));
            check("conf_commit", conf, cur_ev.conf);
            model_conf = cur_ev.conf;
          end
        end
      end else begin
        check("conf_stable", conf, model_conf);
        check("err_code_held", CW'(err_code), CW'(model_code));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after a rising edge
  // ---------------------------------------------------------------------------
  task automatic drive(input bit b);
    uart_data = b;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input byte c, input bit stop_v = 1'b1, input bit par_flip = 1'b0);
    if (!stop_v || par_flip) model_err(2'd0);
    else                     model_byte(c);
    drive(1'b0);
    for (int i = 0; i < 8; i++) drive(c[i]);
`ifdef CONF_PARITY_EN
    drive((^c) ^ par_flip);
`endif
    drive(stop_v);
    drive(1'b1);
  endtask

  task automatic send_line(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic reset_model();
    exp_q.delete();
    model_clear_line();
    model_conf = '0;
    model_code = 2'd0;
  endtask

  task automatic drained(input string name);
    check(name, CW'(exp_q.size()), CW'(0));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish (total=%0d)", total);
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    uart_data = 1'b1;
    rst_n     = 1'b0;
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    check("reset_conf", conf, '0);
    check("reset_conf_valid", CW'(conf_valid), '0);
    check("reset_err", CW'(err), '0);
    check("reset_err_code", CW'(err_code), '0);
    check("reset_state", CW'(state), '0);
    rst_n = 1'b1;
    drive(1'b1);
    drive(1'b1);

    // Basic line
    send_line("7,2,4,2,45\n");
    drained("line1_events");
    check("line1_conf", conf, 80'h002d_0002_0004_0002_0007);
    check("line1_cv_count", CW'(cv_seen), CW'(1));
    check("line1_no_err", CW'(err_seen), CW'(0));

    // Maximum value, then one past it
    send_line("65535,0,1,2,3\n");
    drained("max_events");
    check("max_conf", conf, 80'h0003_0002_0001_0000_ffff);
    send_line("65536,0,1,2,3\n");
    drained("ovf_events");
    check("ovf_code", CW'(err_code), CW'(2));
    check("ovf_conf_kept", CW'(conf[15:0]), CW'(16'hffff));
    check("ovf_cv_count", CW'(cv_seen), CW'(2));
    check("ovf_err_count", CW'(err_seen), CW'(1));

    // Field count and empty field
    send_line("1,2,3\n");
    drained("short_events");
    check("short_code", CW'(err_code), CW'(3));
    send_line("1,,3,4,5\n");
    drained("empty_events");
    send_line("1,2,3,4,5,6\n");
    drained("long_events");
    check("count_code", CW'(err_code), CW'(3));
    check("count_err_count", CW'(err_seen), CW'(4));
    check("count_cv_count", CW'(cv_seen), CW'(2));

    // Illegal character and too many digits
    send_line("1,2,x,4,5\n");
    drained("char_events");
    check("char_code", CW'(err_code), CW'(1));
    send_line("000001,2,3,4,5\n");
    drained("digits_events");
    check("digits_code", CW'(err_code), CW'(2));
    check("digits_err_count", CW'(err_seen), CW'(6));

    // Stop bit forced low; the bad line is closed silently, then a good one
    send_byte(8'h35, 1'b0);
    send_line("\n");
    drained("frame_events");
    check("frame_code", CW'(err_code), CW'(0));
    check("frame_err_count", CW'(err_seen), CW'(7));
    send_line("9,9,9,9,9\n");
    drained("nines_events");
    check("nines_conf", conf, 80'h0009_0009_0009_0009_0009);
    check("nines_cv_count", CW'(cv_seen), CW'(3));

    // Carriage return is ignored
    send_line("3,1,4,1,5\r\n");
    drained("crlf_events");
    check("crlf_conf", conf, 80'h0005_0001_0004_0001_0003);
    check("crlf_cv_count", CW'(cv_seen), CW'(4));

    // 5-cycle glitch on an idle line
    uart_data = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("glitch_start_state", CW'(state), CW'(1));
    drive(1'b1);
    check("glitch_idle_state", CW'(state), CW'(0));
    drive(1'b1);
    check("glitch_err_count", CW'(err_seen), CW'(7));
    check("glitch_cv_count", CW'(cv_seen), CW'(4));

    // Reset in the middle of a frame's data bits
    drive(1'b0);
    drive(1'b1);
    drive(1'b0);
    check("mid_frame_state", CW'(state), CW'(2));
    rst_n     = 1'b0;
    uart_data = 1'b1;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    check("rst2_conf", conf, '0);
    check("rst2_err_code", CW'(err_code), '0);
    check("rst2_state", CW'(state), '0);
    check("rst2_pulses", CW'({conf_valid, err}), '0);
    rst_n = 1'b1;
    drive(1'b1);
    drive(1'b1);
    send_line("7,2,4,2,45\n");
    drained("after_rst_events");
    check("after_rst_conf", conf, 80'h002d_0002_0004_0002_0007);
    check("after_rst_cv_count", CW'(cv_seen), CW'(5));

`ifdef CONF_PARITY_EN
    // Corrupt parity on the '4'
    send_line("7,2,");
    send_byte(8'h34, 1'b1, 1'b1);
    send_line(",2,45\n");
    drained("parity_events");
    check("parity_code", CW'(err_code), CW'(0));
    check("parity_cv_count", CW'(cv_seen), CW'(5));
    check("parity_err_count", CW'(err_seen), CW'(8));
`endif

    drive(1'b1);
    $display("test done: total=%0d bad=%0d", total, bad_cnt);
    $finish;
  end

endmodule
